// File: rtl/eeg_oram_acc_bank_if.sv
`default_nettype none
// ============================================================================
// Module      : eeg_oram_acc_bank_if
// Description : Write, read-address, read-data and clear handshakes of the
//               per-channel EEG output RAM bank, one bit/slice per channel.
// Revision    : 1.0 - initial release
// ============================================================================
interface eeg_oram_acc_bank_if #(
    parameter int CH_NUM = 16,
    parameter int ADD_AW = 8,
    parameter int DAT_DW = 8
);
    logic [CH_NUM-1:0]        clr_req;
    logic [CH_NUM-1:0]        clr_bsy;
    logic [CH_NUM-1:0]        din_vld;
    logic [CH_NUM-1:0]        din_rdy;
    logic [CH_NUM-1:0]        din_acc;
    logic [CH_NUM*ADD_AW-1:0] din_add;
    logic [CH_NUM*DAT_DW-1:0] din_dat;
    logic [CH_NUM-1:0]        add_vld;
    logic [CH_NUM-1:0]        add_lst;
    logic [CH_NUM-1:0]        add_rdy;
    logic [CH_NUM*ADD_AW-1:0] add_add;
    logic [CH_NUM-1:0]        dat_vld;
    logic [CH_NUM-1:0]        dat_lst;
    logic [CH_NUM-1:0]        dat_rdy;
    logic [CH_NUM*DAT_DW-1:0] dat_dat;

    modport master (
        output clr_req, din_vld, din_acc, din_add, din_dat,
               add_vld, add_lst, add_add, dat_rdy,
        input  clr_bsy, din_rdy, add_rdy, dat_vld, dat_lst, dat_dat
    );

    modport slave (
        input  clr_req, din_vld, din_acc, din_add, din_dat,
               add_vld, add_lst, add_add, dat_rdy,
        output clr_bsy, din_rdy, add_rdy, dat_vld, dat_lst, dat_dat
    );
endinterface
`default_nettype wire

// File: rtl/eeg_oram_acc_bank.sv
`default_nettype none
// ============================================================================
// Module      : eeg_oram_acc_bank
// Description : Per-channel 1R1W output RAM with saturating accumulate,
//               2-cycle read into a decoupling FIFO, and bulk-clear sweep.
// Revision    : 1.0 - initial release
// ============================================================================
module eeg_oram_acc_bank #(
    parameter int CH_NUM   = 16,
    parameter int ADD_AW   = 8,
    parameter int DAT_DW   = 8,
    parameter int OF_DEPTH = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    eeg_oram_acc_bank_if.slave    oram
);

    localparam int DEPTH = 2 ** ADD_AW;
    localparam int PTR_W = (OF_DEPTH > 1) ? $clog2(OF_DEPTH) : 1;
    localparam int CNT_W = $clog2(OF_DEPTH + 1) + 1;
    localparam logic [CNT_W-1:0] OF_DEPTH_C = CNT_W'(OF_DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_SWEEP = 2'd2;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(OF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
        logic              din_vld, din_acc, add_vld, add_lst, dat_rdy, clr_req;
        logic [ADD_AW-1:0] din_add, add_add;
        logic [DAT_DW-1:0] din_dat;

        assign clr_req = oram.clr_req[c];
        assign din_vld = oram.din_vld[c];
        assign din_acc = oram.din_acc[c];
        assign din_add = oram.din_add[c*ADD_AW +: ADD_AW];
        assign din_dat = oram.din_dat[c*DAT_DW +: DAT_DW];
        assign add_vld = oram.add_vld[c];
        assign add_lst = oram.add_lst[c];
        assign add_add = oram.add_add[c*ADD_AW +: ADD_AW];
        assign dat_rdy = oram.dat_rdy[c];

        logic [DAT_DW-1:0] mem_q [DEPTH];

        logic [1:0]        state_q, state_d;
        logic [ADD_AW-1:0] sweep_q, sweep_d;
        logic              clr_bsy, din_rdy, add_rdy, sweep_we;

        logic              s2_vld_q, s2_acc_q;
        logic [ADD_AW-1:0] s2_add_q;
        logic [DAT_DW-1:0] s2_dat_q, s2_old_q;
        logic [DAT_DW:0]   s2_sum;
        logic [DAT_DW-1:0] s2_res;

        logic              rd_vld_q, rd_lst_q;
        logic [DAT_DW-1:0] rd_dat_q;

        logic [DAT_DW-1:0]   fifo_dat_q [OF_DEPTH];
        logic [OF_DEPTH-1:0] fifo_lst_q;
        logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
        logic [CNT_W-1:0]    cnt_q, occ;
        logic                push, pop, dat_vld, din_fire, add_fire;
        logic [DAT_DW-1:0]   fwd_din, fwd_add;

        assign din_fire = din_vld & din_rdy;
        assign add_fire = add_vld & add_rdy;
        assign dat_vld  = (cnt_q != '0);
        assign push     = rd_vld_q;
        assign pop      = dat_vld & dat_rdy;
        assign occ      = cnt_q + CNT_W'(rd_vld_q);

        // Operands are sign-extended by one bit so overflow shows as MSB disagreement.
        assign s2_sum = {s2_old_q[DAT_DW-1], s2_old_q} + {s2_dat_q[DAT_DW-1], s2_dat_q};

        always_comb begin
            s2_res = s2_dat_q;
            if (s2_acc_q) begin
                if (s2_sum[DAT_DW] != s2_sum[DAT_DW-1])
                    s2_res = s2_sum[DAT_DW] ? {1'b1, {(DAT_DW-1){1'b0}}}
                                            : {1'b0, {(DAT_DW-1){1'b1}}};
                else
                    s2_res = s2_sum[DAT_DW-1:0];
            end
        end

        // The S2 result commits at the same edge these reads sample, so it is bypassed.
        assign fwd_din = (s2_vld_q && (s2_add_q == din_add)) ? s2_res : mem_q[din_add];
        assign fwd_add = (s2_vld_q && (s2_add_q == add_add)) ? s2_res : mem_q[add_add];

        always_ff @(posedge clk) begin
            if (sweep_we)
                mem_q[sweep_q] <= '0;
            else if (s2_vld_q)
                mem_q[s2_add_q] <= s2_res;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= ST_IDLE;
                sweep_q <= '0;
            end else begin
                state_q <= state_d;
                sweep_q <= sweep_d;
            end
        end

        always_comb begin
            state_d = state_q;
            sweep_d = sweep_q;
            case (state_q)
                ST_IDLE:  if (clr_req) state_d = ST_DRAIN;
                ST_DRAIN: begin
                    sweep_d = '0;
                    state_d = ST_SWEEP;
                end
                ST_SWEEP: begin
                    sweep_d = sweep_q + ADD_AW'(1);
                    if (sweep_q == {ADD_AW{1'b1}}) state_d = ST_IDLE;
                end
                default:  state_d = ST_IDLE;
            endcase
        end

        always_comb begin
            clr_bsy  = (state_q != ST_IDLE);
            sweep_we = (state_q == ST_SWEEP);
            din_rdy  = ~clr_req & (state_q == ST_IDLE);
            add_rdy  = ~din_vld & (state_q == ST_IDLE) & (occ < OF_DEPTH_C);
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s2_vld_q   <= 1'b0;
                s2_acc_q   <= 1'b0;
                s2_add_q   <= '0;
                s2_dat_q   <= '0;
                s2_old_q   <= '0;
                rd_vld_q   <= 1'b0;
                rd_lst_q   <= 1'b0;
                rd_dat_q   <= '0;
                wr_ptr_q   <= '0;
                rd_ptr_q   <= '0;
                cnt_q      <= '0;
                fifo_lst_q <= '0;
                for (int i = 0; i < OF_DEPTH; i++) fifo_dat_q[i] <= '0;
            end else begin
                s2_vld_q <= din_fire;
                if (din_fire) begin
                    s2_acc_q <= din_acc;
                    s2_add_q <= din_add;
                    s2_dat_q <= din_dat;
                    s2_old_q <= fwd_din;
                end
                rd_vld_q <= add_fire;
                if (add_fire) begin
                    rd_lst_q <= add_lst;
                    rd_dat_q <= fwd_add;
                end
                if (push) begin
                    fifo_dat_q[wr_ptr_q] <= rd_dat_q;
                    fifo_lst_q[wr_ptr_q] <= rd_lst_q;
                    wr_ptr_q             <= ptr_inc(wr_ptr_q);
                end
                if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
                case ({push, pop})
                    2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                    2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                    default: cnt_q <= cnt_q;
                endcase
            end
        end

        assign oram.clr_bsy[c]                   = clr_bsy;
        assign oram.din_rdy[c]                   = din_rdy;
        assign oram.add_rdy[c]                   = add_rdy;
        assign oram.dat_vld[c]                   = dat_vld;
        assign oram.dat_lst[c]                   = fifo_lst_q[rd_ptr_q];
        assign oram.dat_dat[c*DAT_DW +: DAT_DW]  = fifo_dat_q[rd_ptr_q];
    end

endmodule
`default_nettype wire

// File: tb/tb_eeg_oram_acc_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_eeg_oram_acc_bank
// Description : Directed self-checking bench for eeg_oram_acc_bank.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_eeg_oram_acc_bank;

    localparam int CH_NUM   = 16;
    localparam int ADD_AW   = 8;
    localparam int DAT_DW   = 8;
    localparam int OF_DEPTH = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    eeg_oram_acc_bank_if #(.CH_NUM(CH_NUM), .ADD_AW(ADD_AW), .DAT_DW(DAT_DW)) bus ();

    eeg_oram_acc_bank #(
        .CH_NUM(CH_NUM), .ADD_AW(ADD_AW), .DAT_DW(DAT_DW), .OF_DEPTH(OF_DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .oram  (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one write and returns right after it is accepted; din_vld stays high.
    task automatic wr(input int c, input logic [7:0] a, input logic [7:0] d, input logic acc);
        int n;
        bus.din_vld[c] = 1'b1;
        bus.din_acc[c] = acc;
        bus.din_add[c*ADD_AW +: ADD_AW] = a;
        bus.din_dat[c*DAT_DW +: DAT_DW] = d;
        #1;
        n = 0;
        while (!bus.din_rdy[c] && n < 20) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk("wr_rdy", 32'(bus.din_rdy[c]), 32'd1);
        step();
    endtask

    task automatic wr_end(input int c);
        bus.din_vld[c] = 1'b0;
        bus.din_acc[c] = 1'b0;
    endtask

    task automatic rd(input int c, input logic [7:0] a, input logic lst,
                      input logic [7:0] exp, input string tag);
        int n;
        bus.add_vld[c] = 1'b1;
        bus.add_lst[c] = lst;
        bus.add_add[c*ADD_AW +: ADD_AW] = a;
        #1;
        n = 0;
        while (!bus.add_rdy[c] && n < 20) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk({tag, "_add_rdy"}, 32'(bus.add_rdy[c]), 32'd1);
        step();
        bus.add_vld[c] = 1'b0;
        bus.add_lst[c] = 1'b0;
        step();
        chk({tag, "_vld"}, 32'(bus.dat_vld[c]), 32'd1);
        chk({tag, "_dat"}, 32'(bus.dat_dat[c*DAT_DW +: DAT_DW]), 32'(exp));
        chk({tag, "_lst"}, 32'(bus.dat_lst[c]), 32'(lst));
        step();
    endtask

    logic [7:0] bp_add [6] = '{8'd3, 8'd4, 8'd6, 8'd5, 8'd7, 8'd3};
    logic [7:0] bp_exp [6] = '{8'h7F, 8'h80, 8'h14, 8'h12, 8'h1E, 8'h7F};
    logic [7:0] cl_add [5] = '{8'd0, 8'd1, 8'd128, 8'd255, 8'd77};

    initial begin
        int acc_n, out_n, n;
        logic seen;

        bus.clr_req = '0;
        bus.din_vld = '0;
        bus.din_acc = '0;
        bus.din_add = '0;
        bus.din_dat = '0;
        bus.add_vld = '0;
        bus.add_lst = '0;
        bus.add_add = '0;
        bus.dat_rdy = '1;

        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        step();
        chk("rst_din_rdy", 32'(bus.din_rdy), 32'h0000_FFFF);
        chk("rst_add_rdy", 32'(bus.add_rdy), 32'h0000_FFFF);
        chk("rst_dat_vld", 32'(bus.dat_vld), 32'd0);
        chk("rst_clr_bsy", 32'(bus.clr_bsy), 32'd0);
        chk("rst_dat_lst", 32'(bus.dat_lst), 32'd0);

        // Plain write then read in the next cycle, latency checked cycle by cycle.
        bus.din_vld[0] = 1'b1;
        bus.din_add[0 +: ADD_AW] = 8'd5;
        bus.din_dat[0 +: DAT_DW] = 8'h12;
        #1 chk("pw_din_rdy", 32'(bus.din_rdy[0]), 32'd1);
        chk("pw_add_rdy_wr", 32'(bus.add_rdy[0]), 32'd0);
        step();
        bus.din_vld[0] = 1'b0;
        bus.add_vld[0] = 1'b1;
        bus.add_lst[0] = 1'b1;
        bus.add_add[0 +: ADD_AW] = 8'd5;
        #1 chk("pw_add_rdy", 32'(bus.add_rdy[0]), 32'd1);
        step();
        bus.add_vld[0] = 1'b0;
        bus.add_lst[0] = 1'b0;
        #1 chk("pw_vld_t1", 32'(bus.dat_vld[0]), 32'd0);
        step();
        chk("pw_vld_t2", 32'(bus.dat_vld[0]), 32'd1);
        chk("pw_dat", 32'(bus.dat_dat[0 +: DAT_DW]), 32'h12);
        chk("pw_lst", 32'(bus.dat_lst[0]), 32'd1);
        step();
        chk("pw_pop", 32'(bus.dat_vld[0]), 32'd0);

        // Accumulate: back-to-back writes rely on the S2 bypass.
        wr(0, 8'd3, 8'd100, 1'b0);
        wr(0, 8'd3, 8'd100, 1'b1);
        wr_end(0);
        rd(0, 8'd3, 1'b0, 8'h7F, "acc_satpos");
        wr(0, 8'd4, 8'h9C, 1'b0);
        wr(0, 8'd4, 8'h9C, 1'b1);
        wr_end(0);
        rd(0, 8'd4, 1'b0, 8'h80, "acc_satneg");
        wr(0, 8'd6, 8'd10, 1'b0);
        wr(0, 8'd6, 8'd5, 1'b1);
        wr(0, 8'd6, 8'd5, 1'b1);
        wr_end(0);
        rd(0, 8'd6, 1'b0, 8'h14, "acc_chain");
        wr(0, 8'd7, 8'h32, 1'b0);
        wr(0, 8'd7, 8'hEC, 1'b1);
        wr_end(0);
        rd(0, 8'd7, 1'b1, 8'h1E, "acc_mixed");

        // Backpressure: only OF_DEPTH reads fit while DAT_RDY is low.
        bus.dat_rdy[0] = 1'b0;
        acc_n = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            bus.add_vld[0] = (acc_n < 6);
            bus.add_add[0 +: ADD_AW] = bp_add[acc_n % 6];
            bus.add_lst[0] = (acc_n == 5);
            #1;
            if (bus.add_vld[0] && bus.add_rdy[0]) acc_n++;
            step();
        end
        #1;
        chk("bp_accepted", 32'(acc_n), 32'd3);
        chk("bp_add_rdy_low", 32'(bus.add_rdy[0]), 32'd0);
        chk("bp_dat_vld", 32'(bus.dat_vld[0]), 32'd1);
        bus.dat_rdy[0] = 1'b1;
        out_n = 0;
        for (int cyc = 0; cyc < 40 && out_n < 6; cyc++) begin
            bus.add_vld[0] = (acc_n < 6);
            bus.add_add[0 +: ADD_AW] = bp_add[acc_n % 6];
            bus.add_lst[0] = (acc_n == 5);
            #1;
            if (bus.add_vld[0] && bus.add_rdy[0]) acc_n++;
            if (bus.dat_vld[0]) begin
                chk($sformatf("bp_dat%0d", out_n), 32'(bus.dat_dat[0 +: DAT_DW]), 32'(bp_exp[out_n]));
                chk($sformatf("bp_lst%0d", out_n), 32'(bus.dat_lst[0]), 32'(out_n == 5));
                out_n++;
            end
            step();
        end
        bus.add_vld[0] = 1'b0;
        bus.add_lst[0] = 1'b0;
        chk("bp_words", 32'(out_n), 32'd6);

        // Priority: write wins over read on ch2, ch3 keeps reading.
        bus.din_vld[2] = 1'b1;
        bus.din_add[2*ADD_AW +: ADD_AW] = 8'd9;
        bus.din_dat[2*DAT_DW +: DAT_DW] = 8'h55;
        bus.add_vld[2] = 1'b1;
        bus.add_add[2*ADD_AW +: ADD_AW] = 8'd9;
        bus.add_vld[3] = 1'b1;
        bus.add_add[3*ADD_AW +: ADD_AW] = 8'd0;
        #1;
        chk("pri_din_rdy2", 32'(bus.din_rdy[2]), 32'd1);
        chk("pri_add_rdy2", 32'(bus.add_rdy[2]), 32'd0);
        chk("pri_add_rdy3", 32'(bus.add_rdy[3]), 32'd1);
        step();
        bus.din_vld[2] = 1'b0;
        bus.add_vld[3] = 1'b0;
        #1 chk("pri_add_rdy2_free", 32'(bus.add_rdy[2]), 32'd1);
        step();
        bus.add_vld[2] = 1'b0;
        chk("pri_ch3_vld", 32'(bus.dat_vld[3]), 32'd1);
        step();
        chk("pri_ch2_vld", 32'(bus.dat_vld[2]), 32'd1);
        chk("pri_ch2_dat", 32'(bus.dat_dat[2*DAT_DW +: DAT_DW]), 32'h55);
        step();

        // Clear sweep on ch1.
        wr(1, 8'd0, 8'h11, 1'b0);
        wr(1, 8'd1, 8'h22, 1'b0);
        wr(1, 8'd128, 8'h33, 1'b0);
        wr(1, 8'd255, 8'h44, 1'b0);
        wr(1, 8'd77, 8'h66, 1'b0);
        wr_end(1);
        rd(1, 8'd128, 1'b0, 8'h33, "cl_pre");
        bus.clr_req[1] = 1'b1;
        #1 chk("cl_din_rdy_req", 32'(bus.din_rdy[1]), 32'd0);
        step();
        bus.clr_req[1] = 1'b0;
        n = 0;
        seen = 1'b0;
        while (bus.clr_bsy[1] && n < 400) begin
            seen = seen | bus.din_rdy[1] | bus.add_rdy[1];
            n++;
            step();
        end
        chk("cl_bsy_len", 32'(n), 32'd257);
        chk("cl_rdy_low", 32'(seen), 32'd0);
        for (int i = 0; i < 5; i++)
            rd(1, cl_add[i], 1'b0, 8'h00, $sformatf("cl_zero%0d", i));

        // Reset in the middle of a sweep.
        bus.clr_req[1] = 1'b1;
        step();
        bus.clr_req[1] = 1'b0;
        repeat (50) step();
        chk("rs_bsy_mid", 32'(bus.clr_bsy[1]), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rs_bsy_async", 32'(bus.clr_bsy[1]), 32'd0);
        chk("rs_din_rdy", 32'(bus.din_rdy), 32'h0000_FFFF);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("rs_bsy_after", 32'(bus.clr_bsy), 32'd0);
        wr(1, 8'd9, 8'h5A, 1'b0);
        wr_end(1);
        rd(1, 8'd9, 1'b1, 8'h5A, "rs_rw");

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
`default_nettype wire
